muldiv_unit: RTL
================

# muldiv_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers, sitting directly downstream of the `RegisterFile` read ports. It consumes `ReadData1`/`ReadData2` as operands for MULT, MULTU, DIV and DIVU and holds results in HI/LO for later MFHI/MFLO. The control unit stalls on `Busy`.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width; only 32 is supported.

Ports (name, direction, width, meaning):
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `Start`  in  1  request to begin an operation.
- `Op`  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `OperandA`  in  32  multiplicand / dividend; driven from `ReadData1`.
- `OperandB`  in  32  multiplier / divisor; driven from `ReadData2`.
- `MtHi`  in  1  write `OperandA` into HI.
- `MtLo`  in  1  write `OperandA` into LO.
- `Busy`  out  1  an operation is in progress.
- `Done`  out  1  one-cycle pulse when HI/LO hold a new result.
- `DivZero`  out  1  one-cycle pulse, coincident with `Done`, for a divide with `OperandB`=0.
- `HI`  out  32  HI register.
- `LO`  out  32  LO register.

## Operation
- States are IDLE, CALC, FIX and DONE.
- `Start` is accepted only in IDLE or DONE. On acceptance:
  - `Op` and the magnitudes of `OperandA`/`OperandB` are latched into internal registers (signed ops take the absolute value).
  - The result signs are recorded.
  - The state moves to CALC with the iteration counter at 0.
- `Start` in CALC or FIX is ignored. There is no queueing.
- CALC performs one radix-2 step per cycle for 32 cycles, using a 6-bit counter:
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, producing a 32-bit quotient and a 32-bit remainder.
  - Counter value 31 transitions to FIX.
- FIX applies sign correction, writes HI/LO, and transitions to DONE.
- Multiply results: {HI,LO} is the 64-bit product, two's complement for MULT.
- Divide results: LO is the quotient, HI is the remainder.
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No trap.
- Divide by zero completes normally in 34 cycles with HI=dividend (as signed input) and LO=0xFFFFFFFF. `DivZero` pulses.
- DONE lasts one cycle, then the state returns to IDLE unless `Start` is accepted.
- `MtHi`/`MtLo` are honoured only when `Busy`=0. They are ignored while busy.
- If `MtHi`/`MtLo` and an accepted `Start` occur on the same edge, the MT write lands first. The operation later overwrites both registers.

## Timing
- Reset (asynchronous, `reset_n`=0): state=IDLE, counter=0, HI=0, LO=0, `Busy`=0, `Done`=0, `DivZero`=0. Reset applies immediately, including mid-CALC. The partial result is discarded and HI/LO are cleared.
- Edge numbering starts with `Start` accepted at edge 0:
  - `Busy`=1 from just after edge 0 until edge 33.
  - CALC occupies edges 1..32.
  - FIX updates HI/LO at edge 33.
  - `Done`/`DivZero` are high for the single cycle after edge 33.
- Latency from `Start` to a valid HI/LO is 33 clocks. Issue interval is 34 clocks, because `Start` is accepted during DONE.
- `Busy` is a registered output: a state decode with no combinational path from `Start`.
- Operands may change after edge 0 without affecting the result.
- MT writes take effect at the edge where they are sampled. HI/LO are visible the next cycle.

## Structure
- Shared package `muldiv_pkg` holds:
  - Op encodings: `OP_MULTU`, `OP_MULT`, `OP_DIVU`, `OP_DIV`.
  - State encoding: `S_IDLE`, `S_CALC`, `S_FIX`, `S_DONE`.
  - `ITER_COUNT`=32.
- Single module with no sub-module.
- The datapath is one 64-bit shift register plus one 33-bit adder/subtractor shared between multiply and divide.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, `Done` high exactly one cycle after edge 33, `Busy` high for 33 cycles.
- MULT -3 × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; repeat as MULTU -> HI=0x00000006, LO=0xFFFFFFEB.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 100 / 0 -> HI=100, LO=0xFFFFFFFF, `DivZero`=1 with `Done`; a following DIVU 100/7 -> LO=14, HI=2, `DivZero`=0.
- Second `Start` at edge 5 with different operands is ignored and the first result is unchanged. `MtHi`=1 while busy is ignored. `MtLo` with `OperandA`=0x1234 in IDLE -> LO=0x1234 next cycle.
- `reset_n` low at iteration 10 of a MULT -> `Busy`=0, HI=LO=0 immediately. After release, a new MULTU 6×7 -> LO=42, HI=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the iterative multiply/divide unit
package muldiv_pkg;
  typedef enum logic [1:0] {OP_MULTU = 2'b00, OP_MULT = 2'b01, OP_DIVU = 2'b10, OP_DIV = 2'b11} op_t;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
  localparam int ITER_COUNT = 32;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide with architectural HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             MtHi,
  input  logic             MtLo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  state_t state, state_nxt;
  logic [5:0] cnt;
  logic is_div_q, neg_q, rem_neg_q, zero_q;
  logic [2*WIDTH-1:0] sh, step_nxt, prod;
  logic [WIDTH-1:0] b_q, a_mag, b_mag, quo, rem, hi_fix, lo_fix;
  logic [WIDTH:0] x, y, sum;
  logic accept, is_signed, is_div, a_neg, b_neg;
  assign Busy = state == S_CALC || state == S_FIX;
  assign Done = state == S_DONE;
  assign DivZero = state == S_DONE && zero_q;
  assign accept = Start && !Busy;
  assign is_signed = Op == OP_MULT || Op == OP_DIV;
  assign is_div = Op == OP_DIVU || Op == OP_DIV;
  assign a_neg = is_signed && OperandA[WIDTH-1];
  assign b_neg = is_signed && OperandB[WIDTH-1];
  assign a_mag = a_neg ? -OperandA : OperandA;
  assign b_mag = b_neg ? -OperandB : OperandB;
  assign x = is_div_q ? sh[2*WIDTH-1:WIDTH-1] : {1'b0, sh[2*WIDTH-1:WIDTH]};
  assign y = is_div_q ? ~{1'b0, b_q} : {1'b0, b_q};
  assign sum = x + y + (WIDTH+1)'(is_div_q);
  assign step_nxt = is_div_q ? (sum[WIDTH] ? {sh[2*WIDTH-2:0], 1'b0} : {sum[WIDTH-1:0], sh[WIDTH-2:0], 1'b1})
                             : (sh[0] ? {sum, sh[WIDTH-1:1]} : {1'b0, sh[2*WIDTH-1:1]});
  assign prod = neg_q ? -sh : sh;
  assign quo = zero_q ? '1 : neg_q ? -sh[WIDTH-1:0] : sh[WIDTH-1:0];
  assign rem = rem_neg_q ? -sh[2*WIDTH-1:WIDTH] : sh[2*WIDTH-1:WIDTH];
  assign hi_fix = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
  assign lo_fix = is_div_q ? quo : prod[WIDTH-1:0];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = accept ? S_CALC
              : state == S_CALC ? (cnt == 6'(ITER_COUNT - 1) ? S_FIX : S_CALC)
              : state == S_FIX ? S_DONE : S_IDLE;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      sh <= '0;
      b_q <= '0;
      is_div_q <= 1'b0;
      neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      sh <= {{WIDTH{1'b0}}, a_mag};
      b_q <= b_mag;
      is_div_q <= is_div;
      neg_q <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
      zero_q <= is_div && OperandB == '0;
    end else if (state == S_CALC) begin
      cnt <= cnt + 6'd1;
      sh <= step_nxt;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      HI <= '0;
      LO <= '0;
    end else if (state == S_FIX) begin
      HI <= hi_fix;
      LO <= lo_fix;
    end else if (!Busy) begin
      if (MtHi) HI <= OperandA;
      if (MtLo) LO <= OperandA;
    end
  end
endmodule
